// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the ID-stage RAW hazard scoreboard:
// register address width, opcodes, scoreboard entry layout and FSM states.
package id_hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd3;
  localparam logic [5:0] OP_OR  = 6'd7;
  localparam logic [5:0] OP_ST  = 6'd37;
  localparam logic [5:0] OP_BNE = 6'd41;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
  } sb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// ID-stage side of the hazard controller: decoded register fields and branch
// flush in, pipeline freeze/bubble controls out.
interface id_hazard_scoreboard_if;
  import id_hazard_scoreboard_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  src2_used;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_wb_en;
  logic                  flush_in;
  logic                  freeze;
  logic                  bubble;

  modport master (
    output id_valid, src1, src2, src2_used, id_dest, id_wb_en, flush_in,
    input  freeze, bubble
  );

  modport slave (
    input  id_valid, src1, src2, src2_used, id_dest, id_wb_en, flush_in,
    output freeze, bubble
  );

endinterface

// File: rtl/id_hazard_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// RAW hazard controller beside ID: tracks EXE/MEM destinations, freezes IF/ID
// and bubbles ID/EX while ID reads a pending register; keeps stall statistics.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int TRACK_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  id_hazard_scoreboard_if.slave  bus,
  output logic                   stalled,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       stall_events
);

  sb_entry_t              ent [TRACK_DEPTH];
  logic [TRACK_DEPTH-1:0] hit;
  logic                   hz;
  logic                   issue;
  state_t                 state;

  genvar g;
  generate
    for (g = 0; g < TRACK_DEPTH; g++) begin : g_cmp
      assign hit[g] = ent[g].valid &
                      ((ent[g].dest == bus.src1) |
                       (bus.src2_used & (ent[g].dest == bus.src2)));
    end
  endgenerate

  // r0 is never entered, so a zero source can never match a valid entry.
  assign hz         = bus.id_valid & (|hit);
  assign bus.freeze = hz & ~bus.flush_in;
  assign bus.bubble = bus.freeze | bus.flush_in;
  assign issue      = bus.id_valid & bus.id_wb_en & (bus.id_dest != '0) &
                      ~bus.freeze & ~bus.flush_in;

  // The array shifts every cycle; a stalled or flushed slot enters as invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        ent[i] <= '0;
      end
    end else begin
      ent[0] <= '{valid: issue, dest: bus.id_dest};
      for (int i = 1; i < TRACK_DEPTH; i++) begin
        ent[i] <= ent[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      stalled <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.freeze) begin
            state   <= STALL;
            stalled <= 1'b1;
          end
        end
        STALL: begin
          if (!bus.freeze) begin
            state   <= RUN;
            stalled <= 1'b0;
          end
        end
        default: begin
          state   <= RUN;
          stalled <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.freeze),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_events (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.freeze & (state == RUN)),
    .count (stall_events)
  );

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: expected pipeline controls and
// statistics are queued per driven cycle and compared just after the inputs settle.
module tb_id_hazard_scoreboard;
  import id_hazard_scoreboard_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic             freeze;
    logic             bubble;
    logic             stalled;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] events;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             stalled;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] stall_events;

  exp_t expQ[$];
  int   passCount  = 0;
  int   failCount  = 0;
  int   checkCount = 0;
  logic mState     = 1'b0;
  int   mCycles    = 0;
  int   mEvents    = 0;

  id_hazard_scoreboard_if bus ();

  id_hazard_scoreboard #(
    .TRACK_DEPTH (2),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .stalled      (stalled),
    .stall_cycles (stall_cycles),
    .stall_events (stall_events)
  );

  always #5 clk = ~clk;

  task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checkField("queue_empty", 8'd1, 8'd0);
    end else begin
      e = expQ.pop_front();
      checkField("freeze",       {7'd0, bus.freeze},    {7'd0, e.freeze});
      checkField("bubble",       {7'd0, bus.bubble},    {7'd0, e.bubble});
      checkField("stalled",      {7'd0, stalled},       {7'd0, e.stalled});
      checkField("stall_cycles", {4'd0, stall_cycles},  {4'd0, e.cycles});
      checkField("stall_events", {4'd0, stall_events},  {4'd0, e.events});
    end
  endtask

  // One pipeline cycle: drive ID fields, queue the expected controls and
  // statistics, compare, then advance the reference FSM/counter model.
  task automatic applyStimulus(input logic r, input logic v, input logic [4:0] s1,
                               input logic [4:0] s2, input logic s2u, input logic [4:0] d,
                               input logic wb, input logic fl, input logic expFreeze);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus.id_valid  = v;
    bus.src1      = s1;
    bus.src2      = s2;
    bus.src2_used = s2u;
    bus.id_dest   = d;
    bus.id_wb_en  = wb;
    bus.flush_in  = fl;
    e.freeze  = expFreeze;
    e.bubble  = expFreeze | fl;
    e.stalled = mState;
    e.cycles  = CNT_W'(mCycles);
    e.events  = CNT_W'(mEvents);
    expQ.push_back(e);
    #1 checkOutput();
    if (r) begin
      mState  = 1'b0;
      mCycles = 0;
      mEvents = 0;
    end else begin
      if (expFreeze) begin
        if (mCycles < CNT_MAX) mCycles++;
        if (!mState && mEvents < CNT_MAX) mEvents++;
      end
      mState = expFreeze;
    end
  endtask

  task automatic step(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic s2u, input logic [4:0] d, input logic wb,
                      input logic fl, input logic expFreeze);
    applyStimulus(1'b0, v, s1, s2, s2u, d, wb, fl, expFreeze);
  endtask

  task automatic resetStep();
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.id_valid  = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.src2_used = 1'b0;
    bus.id_dest   = '0;
    bus.id_wb_en  = 1'b0;
    bus.flush_in  = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then back-to-back dependency: ADD r3,r1,r2 ; SUB r4,r3,r5
    resetStep();
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
    step(1, 5'd3, 5'd5, 1, 5'd4, 1, 0, 1);
    step(1, 5'd3, 5'd5, 1, 5'd4, 1, 0, 1);
    step(1, 5'd3, 5'd5, 1, 5'd4, 1, 0, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);

    // Gap of one: ADD r3 ; NOP ; OR r6,r7,r3, then immediate reading r3 as src2 field
    resetStep();
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    step(1, 5'd7, 5'd3, 1, 5'd6, 1, 0, 1);
    step(1, 5'd7, 5'd3, 1, 5'd6, 1, 0, 0);
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
    step(1, 5'd7, 5'd3, 0, 5'd9, 1, 0, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);

    // r0 destination and a non-writing store never create hazards
    resetStep();
    step(1, 5'd1, 5'd2, 1, 5'd0, 1, 0, 0);
    step(1, 5'd0, 5'd5, 1, 5'd4, 1, 0, 0);
    step(1, 5'd2, 5'd8, 1, 5'd8, 0, 0, 0);
    step(1, 5'd8, 5'd1, 1, 5'd10, 1, 0, 0);
    step(1, 5'd1, 5'd8, 1, 5'd11, 1, 0, 0);

    // Flush in the first would-be freeze cycle wins over the hazard
    resetStep();
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
    step(1, 5'd3, 5'd5, 1, 5'd4, 1, 1, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);

    // Reset pulsed in the first freeze cycle clears the scoreboard
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
    applyStimulus(1, 1, 5'd3, 5'd5, 1, 5'd4, 1, 0, 1);
    step(1, 5'd3, 5'd5, 1, 5'd4, 1, 0, 0);
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);

    // Saturation: chain of r3 <- r3 ops gives 20 frozen cycles on a 4-bit counter
    resetStep();
    step(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(1, 5'd3, 5'd3, 1, 5'd3, 1, 0, 1);
      step(1, 5'd3, 5'd3, 1, 5'd3, 1, 0, 1);
      step(1, 5'd3, 5'd3, 1, 5'd3, 1, 0, 0);
    end
    step(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkField("sat_cycles_final", {4'd0, stall_cycles}, 8'd15);
    checkField("sat_events_final", {4'd0, stall_events}, 8'd10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
